// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use stall, execute branch redirect and MDU occupancy.
// Define PIPE_CTRL_MDU_EN to build MDU sequencing (BUSY state and latency counter).
module pipe_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_stallreq_i,
   input  logic                  exe_branch_i,
   input  logic [ADDR_WIDTH-1:0] exe_branch_addr_i,
   input  logic                  exe_mdu_req_i,
   input  logic                  exe_mdu_div_i,
   output logic [4:0]            stall_o,
   output logic                  flush_o,
   output logic [ADDR_WIDTH-1:0] new_pc_o,
   output logic                  mdu_done_o,
   output logic                  busy_o
);

   localparam int unsigned CNT_W   = 6;
   localparam int unsigned LAT_W   = 7;
   localparam logic [4:0]  STALL_LU  = 5'b00011;
   localparam logic [4:0]  STALL_MDU = 5'b00111;

`ifdef PIPE_CTRL_MDU_EN
   typedef enum logic {RUN, BUSY} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [LAT_W-1:0]   lat;

   assign lat = exe_mdu_div_i ? LAT_W'(DIV_CYCLES) : LAT_W'(MUL_CYCLES);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      stall_o    = '0;
      flush_o    = 1'b0;
      new_pc_o   = '0;
      mdu_done_o = 1'b0;
      busy_o     = 1'b0;
      state_nxt  = state;
      cnt_nxt    = cnt;
      if (rst_i) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else if (state == BUSY && exe_mdu_req_i) begin
         // Execute holds the MDU op, so a branch cannot be resolved here
         busy_o = 1'b1;
         if (cnt != '0) begin
            stall_o = STALL_MDU;
            cnt_nxt = cnt - CNT_W'(1);
         end else begin
            mdu_done_o = 1'b1;
            stall_o    = id_stallreq_i ? STALL_LU : 5'b00000;
            state_nxt  = RUN;
         end
      end else begin
         // RUN rules; also covers an op withdrawn early while BUSY
         busy_o    = (state == BUSY);
         state_nxt = RUN;
         if (exe_branch_i) begin
            flush_o  = 1'b1;
            new_pc_o = exe_branch_addr_i;
         end else if (exe_mdu_req_i && lat == LAT_W'(1)) begin
            mdu_done_o = 1'b1;
            stall_o    = id_stallreq_i ? STALL_LU : 5'b00000;
         end else if (exe_mdu_req_i) begin
            stall_o   = STALL_MDU;
            cnt_nxt   = CNT_W'(lat - LAT_W'(2));
            state_nxt = BUSY;
         end else if (id_stallreq_i) begin
            stall_o = STALL_LU;
         end
      end
   end
`else
   logic unused_mdu;
   assign unused_mdu = ^{clk_i, exe_mdu_req_i, exe_mdu_div_i,
                         LAT_W'(MUL_CYCLES), LAT_W'(DIV_CYCLES), CNT_W'(0)};

   always_comb begin
      stall_o    = '0;
      flush_o    = 1'b0;
      new_pc_o   = '0;
      mdu_done_o = 1'b0;
      busy_o     = 1'b0;
      if (!rst_i) begin
         if (exe_branch_i) begin
            flush_o  = 1'b1;
            new_pc_o = exe_branch_addr_i;
         end else if (id_stallreq_i) begin
            stall_o = STALL_LU;
         end
      end
   end
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RV core. It merges the decode-stage load-use stall request, the execute-stage branch redirect and the multi-cycle multiply/divide (MDU) occupancy of execute into one per-register stall vector, a flush pulse and a redirect PC. It sits beside the pipeline registers (pc, if_id, id_exe, exe_mem, mem_wb), which consume its outputs.

## Interface
- `MUL_CYCLES`, default 4: execute occupancy of a multiply, in cycles. Legal range 1..64.
- `DIV_CYCLES`, default 33: execute occupancy of a divide/remainder, in cycles. Legal range 1..64.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `id_stallreq_i`  in  1  load-use hazard detected in decode. Level signal.
- `exe_branch_i`  in  1  taken branch or jump resolved in execute.
- `exe_branch_addr_i`  in  `ADDR_WIDTH`  redirect target.
- `exe_mdu_req_i`  in  1  execute holds an M-extension op. Level signal, held while the op is in execute.
- `exe_mdu_div_i`  in  1  1 = divide/remainder latency, 0 = multiply latency. Valid with `exe_mdu_req_i`.
- `stall_o`  out  5  hold bits: [0] pc, [1] if_id, [2] id_exe, [3] exe_mem, [4] mem_wb.
- `flush_o`  out  1  kill if_id and id_exe contents (load NOP).
- `new_pc_o`  out  `ADDR_WIDTH`  pc load value, valid when `flush_o`=1.
- `mdu_done_o`  out  1  MDU result valid in execute this cycle.
- `busy_o`  out  1  FSM in MDU_BUSY.

## Operation
- Stall rule for consumers:
  - A register whose stall bit is 1 holds its value.
  - The first register downstream of a held one, with its own bit 0, loads a bubble (`NOP`, write disabled).
- FSM has two states, RUN and BUSY. The counter `cnt` is 6 bits.
- The latency selected for the current op is LAT = `exe_mdu_div_i` ? `DIV_CYCLES` : `MUL_CYCLES`.
- RUN, priority order:
  1. `exe_branch_i`:
     - `flush_o`=1, `new_pc_o`=`exe_branch_addr_i`, `stall_o`=0.
     - `id_stallreq_i` and `exe_mdu_req_i` are ignored this cycle.
  2. `exe_mdu_req_i` with LAT=1: `mdu_done_o`=1, stay RUN. The stall comes from `id_stallreq_i` only.
  3. `exe_mdu_req_i` with LAT>1: `stall_o`=5'b00111, `cnt`<=LAT-2, next state BUSY.
  4. `id_stallreq_i`: `stall_o`=5'b00011, which injects a bubble into id_exe.
  5. Otherwise all outputs are 0.
- BUSY:
  - `cnt`!=0: `stall_o`=5'b00111, `cnt`<=`cnt`-1.
  - `cnt`==0: `mdu_done_o`=1. `stall_o`=5'b00011 if `id_stallreq_i`, else 0. Next state RUN.
  - `exe_mdu_req_i` dropping early: abort to RUN next cycle, no `mdu_done_o`, `stall_o` follows the RUN rules that cycle.
  - `exe_branch_i` is ignored in BUSY, because execute holds the MDU op.
- Back-to-back MDU ops: the op following a done cycle is seen fresh in RUN and gets its full latency.

## Timing
- Registered: state and `cnt`.
- Combinational from state, `cnt` and inputs in the same cycle: `stall_o`, `flush_o`, `new_pc_o`, `mdu_done_o`, `busy_o`. There is no input-to-output register.
- MDU op first seen at cycle T:
  - `stall_o` bit 2 is set T..T+LAT-2.
  - `mdu_done_o` is high at T+LAT-1.
  - exe_mem captures the result at the end of T+LAT-1.
- Load-use: a single-cycle stall per cycle of `id_stallreq_i`, with no added latency.
- Reset: while `rst_i`=1, every output is 0 (`stall_o`=0, `flush_o`=0, `new_pc_o`=0, `mdu_done_o`=0, `busy_o`=0). On the next edge, state<=RUN and `cnt`<=0. This applies equally mid-BUSY.

## Configuration
- `PIPE_CTRL_MDU_EN` defined:
  - MDU sequencing, BUSY state and counter are built as above.
- Undefined:
  - No BUSY state or counter.
  - `exe_mdu_req_i` and `exe_mdu_div_i` are ignored.
  - `mdu_done_o`=0 and `busy_o`=0 constantly.
  - Only the branch and load-use rules apply.

## Test plan
- **Reset mid-divide.** Start a DIV, assert `rst_i` at T+5. Required: all outputs 0 during reset; state RUN and `stall_o`=0 after release with `exe_mdu_req_i`=0.
- **Load-use.** `id_stallreq_i`=1 for one cycle. Required: `stall_o`=5'b00011 that cycle only, and 0 the next.
- **Multiply (`MUL_CYCLES`=4).** Req at T. Required: `stall_o`=5'b00111 for T..T+2; at T+3 `mdu_done_o`=1 and `stall_o`=0.
- **Divide.** DIV with default 33. Required: 32 stall cycles, then `mdu_done_o` at T+32; with `id_stallreq_i`=1 at T+32, `stall_o`=5'b00011 in that cycle.
- **Branch priority.** `exe_branch_i`, `id_stallreq_i` and `exe_mdu_req_i` all 1 in RUN, addr 0x8000_0040. Required: `flush_o`=1, `new_pc_o`=0x8000_0040, `stall_o`=0, state stays RUN.
- **Back-to-back MUL then DIV.** Required: done pulses at T+3 and T+4+32, with exactly one non-stalled cycle between the two ops.
